// File: rtl/vga_pkg.sv
// Shared definitions for the VGA frame reader.
//   lb_word_t : line-buffer stream word {frame_start, rgb}
//   state_e   : reader FSM states
package vga_pkg;

    localparam int unsigned RGB_SIZE = 12;
    localparam int unsigned FS_BIT   = RGB_SIZE;

    // Stream word presented to the line buffer source port.
    typedef struct packed {
        logic                frame_start;
        logic [RGB_SIZE-1:0] rgb;
    } lb_word_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/vga_pixel_fifo.sv
// Synchronous first-word-fall-through FIFO for returned pixels.
// Ports:
//   clk, rst_n      : clock, async active-low reset
//   push_i, data_i  : write strobe and word
//   pop_i           : consume head (ignored when empty)
//   data_o          : head word, valid while !empty_o
//   full_o, empty_o : occupancy flags
//   count_o         : number of stored words, 0..DEPTH
module vga_pixel_fifo #(
    parameter int unsigned WIDTH = 14,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (do_push && !do_pop)      count_q <= count_q + CW'(1);
            else if (!do_push && do_pop) count_q <= count_q - CW'(1);
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/vga_frame_reader.sv
// Framebuffer raster reader feeding the line buffer stream.
// Walks the framebuffer in raster order, issues fixed-latency reads only
// when the output FIFO has room for every outstanding word, and presents
// buffered pixels as a valid/ready stream {frame_start, rgb}.
// Ports:
//   sys_clk, sys_rst        : clock, async active-low reset
//   enable                  : stream frames while high (frame always completes)
//   fb_rd, fb_addr          : read strobe and word address
//   fb_rdata                : read data, RD_LATENCY cycles after fb_rd
//   line_buffer_data/vld/rdy: output stream
//   busy                    : running, or data in flight/buffered
//   frame_done              : pulse the cycle after the last pixel is popped
module vga_frame_reader #(
    parameter int unsigned RGB_SIZE   = 12,
    parameter int unsigned H_DISPLAY  = 640,
    parameter int unsigned V_DISPLAY  = 480,
    parameter int unsigned AW         = 19,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                enable,
    output logic                fb_rd,
    output logic [AW-1:0]       fb_addr,
    input  logic [RGB_SIZE-1:0] fb_rdata,
    output logic [RGB_SIZE:0]   line_buffer_data,
    output logic                line_buffer_vld,
    input  logic                line_buffer_rdy,
    output logic                busy,
    output logic                frame_done
);

    import vga_pkg::state_e;
    import vga_pkg::ST_IDLE;
    import vga_pkg::ST_RUN;

    localparam int unsigned XW = (H_DISPLAY > 1) ? $clog2(H_DISPLAY) : 1;
    localparam int unsigned YW = (V_DISPLAY > 1) ? $clog2(V_DISPLAY) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH+1);
    localparam int unsigned IW = $clog2(RD_LATENCY+1);
    localparam int unsigned SW = CW + 1;
    localparam int unsigned FW = RGB_SIZE + 2;

    state_e          state_q, state_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [IW-1:0]   inflight_q, inflight_d;
    logic            frame_done_q;

    // Read pipeline: valid, first-pixel tag, last-pixel tag.
    logic [RD_LATENCY-1:0] pv_q, pf_q, pl_q;

    logic            issue_c, last_x_c, last_y_c, first_c;
    logic [SW-1:0]   occ_c;
    logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic [FW-1:0]   fifo_wdata, fifo_head;

    assign last_x_c = (x_q == XW'(H_DISPLAY-1));
    assign last_y_c = (y_q == YW'(V_DISPLAY-1));
    assign first_c  = (x_q == '0) && (y_q == '0);

    // Credit: never have more words buffered or outstanding than FIFO slots.
    assign occ_c   = SW'(fifo_count) + SW'(inflight_q);
    assign issue_c = (state_q == ST_RUN) && (occ_c < SW'(FIFO_DEPTH));

    assign fb_rd   = issue_c;
    assign fb_addr = addr_q;

    // Next-state and raster counters; counters move only on issue.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        addr_d  = addr_q;
        case (state_q)
            ST_IDLE: begin
                x_d    = '0;
                y_d    = '0;
                addr_d = '0;
                if (enable) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (issue_c) begin
                    if (last_x_c) begin
                        x_d = '0;
                        if (last_y_c) begin
                            y_d    = '0;
                            addr_d = '0;
                            if (!enable) state_d = ST_IDLE;
                        end else begin
                            y_d    = y_q + YW'(1);
                            addr_d = addr_q + AW'(1);
                        end
                    end else begin
                        x_d    = x_q + XW'(1);
                        addr_d = addr_q + AW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outstanding read count: +1 on issue, -1 when data lands in the FIFO.
    always_comb begin
        inflight_d = inflight_q;
        if (issue_c && !fifo_push)      inflight_d = inflight_q + IW'(1);
        else if (!issue_c && fifo_push) inflight_d = inflight_q - IW'(1);
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q      <= ST_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            addr_q       <= '0;
            inflight_q   <= '0;
            pv_q         <= '0;
            pf_q         <= '0;
            pl_q         <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            addr_q       <= addr_d;
            inflight_q   <= inflight_d;
            pv_q[0]      <= issue_c;
            pf_q[0]      <= issue_c & first_c;
            pl_q[0]      <= issue_c & last_x_c & last_y_c;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                pv_q[i] <= pv_q[i-1];
                pf_q[i] <= pf_q[i-1];
                pl_q[i] <= pl_q[i-1];
            end
            frame_done_q <= fifo_pop & fifo_head[FW-1];
        end
    end

    // Pipeline output lines up with fb_rdata.
    assign fifo_push  = pv_q[RD_LATENCY-1];
    assign fifo_wdata = {pl_q[RD_LATENCY-1], pf_q[RD_LATENCY-1], fb_rdata};
    assign fifo_pop   = line_buffer_vld & line_buffer_rdy;

    vga_pixel_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (sys_clk),
        .rst_n   (sys_rst),
        .push_i  (fifo_push),
        .data_i  (fifo_wdata),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign line_buffer_vld  = ~fifo_empty;
    assign line_buffer_data = fifo_head[RGB_SIZE:0];
    assign busy             = (state_q == ST_RUN) | (inflight_q != '0) | ~fifo_empty;
    assign frame_done       = frame_done_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Self-checking bench for vga_frame_reader on a 8x4 frame with a memory
// model that returns the address as data.
module tb_vga_frame_reader;

    localparam int RGB  = 12;
    localparam int H    = 8;
    localparam int V    = 4;
    localparam int AWB  = 5;
    localparam int L    = 2;
    localparam int D    = 4;
    localparam int NPIX = H * V;

    logic            sys_clk, sys_rst, enable, fb_rd, vld, rdy, busy, frame_done;
    logic [AWB-1:0]  fb_addr;
    logic [RGB-1:0]  fb_rdata, m0, m1;
    logic [RGB:0]    lb_data;

    int n_cmp = 0;
    int n_err = 0;

    // Scoreboard / model state (owned by the monitor).
    logic [RGB:0] q[$];
    int           exp_addr, n_iss, n_pop, n_done;
    bit           done_exp, hold_prev;
    logic [RGB:0] prev_data;

    vga_frame_reader #(
        .RGB_SIZE   (RGB),
        .H_DISPLAY  (H),
        .V_DISPLAY  (V),
        .AW         (AWB),
        .RD_LATENCY (L),
        .FIFO_DEPTH (D)
    ) dut (
        .sys_clk          (sys_clk),
        .sys_rst          (sys_rst),
        .enable           (enable),
        .fb_rd            (fb_rd),
        .fb_addr          (fb_addr),
        .fb_rdata         (fb_rdata),
        .line_buffer_data (lb_data),
        .line_buffer_vld  (vld),
        .line_buffer_rdy  (rdy),
        .busy             (busy),
        .frame_done       (frame_done)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Two-cycle read latency memory returning the address as data.
    always @(posedge sys_clk) begin
        m0 <= fb_rd ? RGB'(fb_addr) : 12'hBAD;
        m1 <= m0;
    end
    assign fb_rdata = m1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Monitor: scoreboard push on issue, pop/compare on stream transfer.
    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            q.delete();
            exp_addr  = 0;
            n_iss     = 0;
            n_pop     = 0;
            n_done    = 0;
            done_exp  = 1'b0;
            hold_prev = 1'b0;
        end else begin
            chk("frame_done", int'(frame_done), int'(done_exp));
            if (frame_done) n_done++;
            done_exp = 1'b0;
            if (hold_prev) begin
                chk("hold_vld", int'(vld), 1);
                chk("hold_data", int'(lb_data), int'(prev_data));
            end
            hold_prev = vld && !rdy;
            prev_data = lb_data;
            if (vld && rdy) begin
                if (q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL pop_unexpected: got %0d, want none", lb_data);
                end else begin
                    logic [RGB:0] e;
                    e = q.pop_front();
                    chk("pixel", int'(lb_data), int'(e));
                    if (int'(e[RGB-1:0]) == NPIX - 1) done_exp = 1'b1;
                    n_pop++;
                end
            end
            if (fb_rd) begin
                chk("fb_addr", int'(fb_addr), exp_addr);
                q.push_back({(exp_addr == 0), RGB'(exp_addr)});
                n_iss++;
                exp_addr = (exp_addr + 1) % NPIX;
            end
            n_cmp++;
            if (int'(dut.fifo_count) > D) begin
                n_err++;
                $display("FAIL fifo_count: got %0d, want <= %0d", dut.fifo_count, D);
            end
            if (dut.fifo_push && dut.fifo_full && !dut.fifo_pop) begin
                n_cmp++; n_err++;
                $display("FAIL fifo_overflow: got push into full, want none");
            end
        end
    end

    task automatic do_reset();
        @(posedge sys_clk); #3;
        sys_rst = 1'b0; enable = 1'b0; rdy = 1'b1;
        @(posedge sys_clk); #3;
        sys_rst = 1'b1;
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge sys_clk); #1;
            if (!busy) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL %s_timeout: got busy, want idle within %0d", name, budget);
        end
    endtask

    typedef struct {
        int drop_at;   // issue count at which enable drops
        bit rdy_rand;  // 50% random ready
        int stall_at;  // pops before a 10-cycle stall (-1 = none)
        int exp_pix;
        int exp_done;
        bit no_gap;    // expect back-to-back issues
    } vec_t;

    vec_t tbl[4];

    initial begin
        sys_rst = 1'b1; enable = 1'b0; rdy = 1'b1;
        tbl[0] = '{10, 1'b0, -1, 32, 1, 1'b1};
        tbl[1] = '{42, 1'b0, -1, 64, 2, 1'b1};
        tbl[2] = '{10, 1'b0,  4, 32, 1, 1'b0};
        tbl[3] = '{74, 1'b1, -1, 96, 3, 1'b0};

        // Reset state.
        #2 sys_rst = 1'b0;
        #1;
        chk("rst_vld", int'(vld), 0);
        chk("rst_fb_rd", int'(fb_rd), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_fb_addr", int'(fb_addr), 0);
        do_reset();

        // First-pixel latency from the RUN entry cycle.
        begin
            int lat;
            bit seen;
            @(posedge sys_clk); #1 enable = 1'b1;
            @(posedge sys_clk);
            @(negedge sys_clk); #1;
            chk("first_fb_rd", int'(fb_rd), 1);
            chk("first_fb_addr", int'(fb_addr), 0);
            enable = 1'b0;
            lat = 0; seen = 1'b0;
            for (int c = 0; c < 10; c++) begin
                @(posedge sys_clk); lat++;
                @(negedge sys_clk); #1;
                if (vld) begin seen = 1'b1; break; end
            end
            chk("first_vld_latency", seen ? lat : -1, L + 1);
            chk("first_frame_start", int'(lb_data[RGB]), 1);
            wait_idle("lat_drain", 500);
            chk("lat_pixels", n_pop, NPIX);
            chk("lat_done", n_done, 1);
        end

        // Table-driven scenarios.
        for (int t = 0; t < 4; t++) begin
            int  gaps, stall_cnt;
            bit  stalled, fin;
            do_reset();
            gaps = 0; stall_cnt = 0; stalled = 1'b0; fin = 1'b0;
            for (int c = 0; c < 3000; c++) begin
                @(posedge sys_clk); #1;
                enable = (n_iss < tbl[t].drop_at);
                if (stall_cnt > 0)      rdy = 1'b0;
                else if (tbl[t].rdy_rand) rdy = 1'($urandom_range(0, 1));
                else                    rdy = 1'b1;
                @(negedge sys_clk); #1;
                if (!fb_rd && n_iss > 0 && n_iss < tbl[t].exp_pix) gaps++;
                if (stall_cnt > 0) begin
                    if (stall_cnt == 1) begin
                        chk("stall_fb_rd", int'(fb_rd), 0);
                        chk("stall_occupancy", int'(dut.fifo_count) + int'(dut.inflight_q), D);
                    end
                    stall_cnt--;
                end else if (tbl[t].stall_at >= 0 && !stalled && n_pop >= tbl[t].stall_at) begin
                    stall_cnt = 10;
                    stalled   = 1'b1;
                end
                if (!enable && !busy && n_iss > 0) begin fin = 1'b1; break; end
            end
            if (!fin) begin
                n_cmp++; n_err++;
                $display("FAIL scen%0d_timeout: got busy, want idle", t);
            end
            chk($sformatf("scen%0d_pixels", t), n_pop, tbl[t].exp_pix);
            chk($sformatf("scen%0d_issues", t), n_iss, tbl[t].exp_pix);
            chk($sformatf("scen%0d_done", t), n_done, tbl[t].exp_done);
            chk($sformatf("scen%0d_sb_empty", t), q.size(), 0);
            if (tbl[t].no_gap) chk($sformatf("scen%0d_gaps", t), gaps, 0);
            rdy = 1'b1;
            for (int c = 0; c < 4; c++) begin
                @(negedge sys_clk); #1;
                chk($sformatf("scen%0d_idle_fb_rd", t), int'(fb_rd), 0);
            end
        end

        // Re-enable after a completed frame restarts at address 0.
        @(posedge sys_clk); #1 enable = 1'b1;
        begin
            bit seen;
            seen = 1'b0;
            for (int c = 0; c < 20; c++) begin
                @(negedge sys_clk); #1;
                if (fb_rd) begin seen = 1'b1; break; end
            end
            chk("reenable_issue", int'(seen), 1);
            chk("reenable_addr", int'(fb_addr), 0);
        end

        // Asynchronous reset mid-frame.
        for (int c = 0; c < 12; c++) @(posedge sys_clk);
        #3 sys_rst = 1'b0;
        #1;
        chk("midrst_vld", int'(vld), 0);
        chk("midrst_fb_rd", int'(fb_rd), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_fb_addr", int'(fb_addr), 0);
        @(posedge sys_clk); #3 sys_rst = 1'b1;
        begin
            bit seen;
            seen = 1'b0;
            for (int c = 0; c < 20; c++) begin
                @(negedge sys_clk); #1;
                if (fb_rd) begin seen = 1'b1; break; end
            end
            chk("midrst_restart_issue", int'(seen), 1);
            chk("midrst_restart_addr", int'(fb_addr), 0);
            for (int c = 0; c < 40 && !vld; c++) begin
                @(negedge sys_clk); #1;
            end
            chk("midrst_restart_fs", int'(lb_data[RGB]), 1);
        end
        enable = 1'b0;
        wait_idle("midrst_drain", 500);
        chk("midrst_pixels", n_pop, NPIX);
        chk("midrst_done", n_done, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vga_frame_reader.md
Name: vga_frame_reader

Overview:
- Upstream feeder of the VGA sync core; runs entirely in the sys_clk domain.
- Walks a framebuffer memory in raster order over fixed-latency reads.
- Buffers returned pixels in a small FIFO and presents them as a valid/ready stream {frame_start, rgb} to the line buffer source port.
- Issues reads against credits so returned data is never dropped under backpressure.

Parameters:
RGB_SIZE, 12, pixel colour width in bits
H_DISPLAY, 640, visible pixels per line
V_DISPLAY, 480, visible lines per frame
AW, 19, framebuffer word address width; must satisfy 2^AW >= H_DISPLAY*V_DISPLAY
RD_LATENCY, 2, cycles from fb_rd to fb_rdata valid (>=1)
FIFO_DEPTH, 8, output FIFO entries; power of 2, >= RD_LATENCY+1

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  asynchronous reset, active-low
enable  in  1  level; request streaming of frames
fb_rd  out  1  framebuffer read strobe
fb_addr  out  AW  framebuffer read address
fb_rdata  in  RGB_SIZE  read data, valid exactly RD_LATENCY cycles after fb_rd
line_buffer_data  out  RGB_SIZE+1  bit RGB_SIZE = frame_start, [RGB_SIZE-1:0] = rgb
line_buffer_vld  out  1  stream valid
line_buffer_rdy  in  1  stream ready
busy  out  1  high while state RUN or data still in flight/buffered
frame_done  out  1  one-cycle pulse when the last pixel of a frame is popped

Behaviour:
- Reset (sys_rst low, async): state IDLE; x, y, fb_addr = 0; fb_rd = 0; read pipeline valid bits cleared; FIFO empty; line_buffer_vld = 0; busy = 0; frame_done = 0.
- State IDLE:
  - x = y = addr = 0.
  - Moves to RUN on the first cycle with enable = 1.
  - Frames always start at pixel (0,0).
- State RUN:
  - A read issues in a cycle where credit = FIFO_DEPTH - (fifo_count + inflight) > 0.
  - fifo_count and inflight are registered values, so issue is conservative by one cycle; a same-cycle pop does not grant credit.
  - Issue drives fb_rd = 1 and fb_addr = addr.
  - inflight counts reads issued but not yet returned, range 0..RD_LATENCY.
- Raster counters advance only on issue:
  - x increments; when x = H_DISPLAY-1, x -> 0 and y increments.
  - At x = H_DISPLAY-1 and y = V_DISPLAY-1 (last pixel), x, y and addr -> 0.
  - addr increments by 1 per issue; it never exceeds H_DISPLAY*V_DISPLAY-1.
- Frame boundary:
  - At last-pixel issue, if enable = 0 the state goes RUN -> IDLE; otherwise it stays in RUN with no gap cycle.
  - Deasserting enable mid-frame does not stop the frame; the frame always completes.
- Read pipeline:
  - A RD_LATENCY-deep shift register carries valid plus a first-pixel tag (x = 0 and y = 0 at issue).
  - At its output, {tag, fb_rdata} is pushed into the FIFO.
  - Overflow is impossible by the credit rule; a push into a full FIFO is a design error and a bench assertion.
- Output:
  - line_buffer_vld = FIFO not empty; line_buffer_data = FIFO head.
  - Pop on vld & rdy.
  - Data holds stable while vld & !rdy.
  - Simultaneous push and pop is allowed, including when the FIFO is full.
- frame_done pulses in the cycle after the pop of the entry at raster position (H_DISPLAY-1, V_DISPLAY-1); that entry is tracked by a last tag in the pipeline.
- busy = (state == RUN) | (inflight != 0) | FIFO not empty.
- Throughput: 1 pixel/cycle sustained when rdy is held high.
- First-pixel latency: first line_buffer_vld comes RD_LATENCY+1 cycles after the RUN entry cycle (issue, RD_LATENCY, FIFO write).
- Arithmetic: x and y use $clog2 widths of H_DISPLAY and V_DISPLAY; addr is AW bits; no multiplier.

Decomposition:
- Package vga_pkg holds:
  - the stream word layout: typedef of the packed {frame_start, rgb} struct;
  - localparam FS_BIT = RGB_SIZE;
  - state enum {IDLE, RUN}.
- One sub-module, vga_pixel_fifo: synchronous FIFO with parameters WIDTH and DEPTH, ports push/pop/full/empty/count, first-word-fall-through.
- Instantiate it with WIDTH = RGB_SIZE+2 (pixel, frame_start tag, last tag).

Test Plan (H_DISPLAY=8, V_DISPLAY=4, RD_LATENCY=2, FIFO_DEPTH=4, memory model returns addr as data):
- Reset, then enable=1 and rdy=1 -> fb_addr runs 0..31 contiguously. First vld 3 cycles after RUN entry. Data sequence 0..31 with frame_start=1 only on data 0. frame_done one pulse after data 31 pops.
- enable held 2 frames, rdy=1 -> addr wraps 31 -> 0 with no idle cycle. frame_start set on both frame heads. 64 pixels in order.
- Backpressure: rdy=0 for 10 cycles from the 5th pixel -> fb_rd stops after fifo_count + inflight = 4. No FIFO overflow. Data held stable. On release, order resumes without loss or duplication.
- Random rdy (50%) over 3 frames -> scoreboard matches raster order exactly; fifo_count never exceeds 4.
- enable dropped at pixel 10 of a frame -> frame completes through addr 31, state returns to IDLE, busy falls after the final pop. Re-enable -> restarts at addr 0 with frame_start.
- sys_rst asserted mid-frame (async, between clock edges) -> vld, fb_rd, busy go low immediately. After release with enable=1, the next frame starts at addr 0.
